// File: rtl/grid_pkg.sv
// Shared constants, operation encoding and FSM states for the grid claim arbiter.
package grid_pkg;

    localparam int GRID_N = 7;
    localparam int EMPTY  = -1;

    localparam logic OP_CLAIM   = 1'b0;
    localparam logic OP_RELEASE = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CHK  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_e;

endpackage

// File: rtl/grid_claim_arbiter_if.sv
// Requester and grid-memory signal bundle; master is the environment, slave is the arbiter.
interface grid_claim_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);

    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        req_op;
    logic [N_REQ*DATA_W-1:0] req_x;
    logic [N_REQ*DATA_W-1:0] req_y;
    logic [N_REQ*DATA_W-1:0] req_id;
    logic [N_REQ-1:0]        gnt;
    logic                    ok;
    logic                    busy;
    logic                    mem_read;
    logic                    mem_write;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_din;
    logic [DATA_W-1:0]       mem_dout;

    modport master (
        output req, req_op, req_x, req_y, req_id, mem_dout,
        input  gnt, ok, busy, mem_read, mem_write, mem_addr, mem_din
    );

    modport slave (
        input  req, req_op, req_x, req_y, req_id, mem_dout,
        output gnt, ok, busy, mem_read, mem_write, mem_addr, mem_din
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin winner search starting at a rotating pointer; the pointer advances
// past the served requester when adv is pulsed.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             adv,
    input  logic [IDX_W-1:0] adv_idx,
    output logic             found,
    output logic [IDX_W-1:0] win_idx
);

    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N_REQ);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] cand_s;
    logic             take_s;
    logic [IDX_W:0]   nxt_s;

    // First requesting index at or after the pointer, wrapping modulo N_REQ
    always_comb begin
        found   = 1'b0;
        win_idx = ptr_q;
        sum_s   = {(IDX_W+1){1'b0}};
        cand_s  = {IDX_W{1'b0}};
        take_s  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            sum_s   = {1'b0, ptr_q} + (IDX_W+1)'(i);
            cand_s  = (sum_s >= N_W) ? IDX_W'(sum_s - N_W) : IDX_W'(sum_s);
            take_s  = !found && req[cand_s];
            win_idx = take_s ? cand_s : win_idx;
            found   = found | take_s;
        end
    end

    // Pointer moves to the requester after the one just served
    always_comb begin
        nxt_s = {1'b0, adv_idx} + {{IDX_W{1'b0}}, 1'b1};
        if (adv) begin
            ptr_d = (nxt_s >= N_W) ? {IDX_W{1'b0}} : IDX_W'(nxt_s);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= {IDX_W{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/grid_claim_arbiter.sv
// Arbitrates claim/release requests onto a shared grid memory with an atomic
// read-check-write sequence; one operation in flight, all outputs registered.
module grid_claim_arbiter #(
    parameter int N_REQ  = 4,
    parameter int GRID_N = grid_pkg::GRID_N,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int EMPTY  = grid_pkg::EMPTY
) (
    input logic                 clk,
    input logic                 reset,
    grid_claim_arbiter_if.slave bus
);

    import grid_pkg::state_e;
    import grid_pkg::IDLE;
    import grid_pkg::RD;
    import grid_pkg::CHK;
    import grid_pkg::WR;
    import grid_pkg::RESP;
    import grid_pkg::OP_CLAIM;

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic signed [DATA_W-1:0] ZERO_S = {DATA_W{1'b0}};
    localparam logic signed [DATA_W-1:0] GMAX_S = DATA_W'(GRID_N - 1);
    localparam logic signed [DATA_W-1:0] GN_S   = DATA_W'(GRID_N);
    localparam logic [DATA_W-1:0]        EMPTY_V = DATA_W'(EMPTY);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic              op_q, op_d;
    logic [DATA_W-1:0] id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              ok_q, ok_d;
    logic              busy_q, busy_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;

    logic signed [DATA_W-1:0] x_arr_s  [N_REQ];
    logic signed [DATA_W-1:0] y_arr_s  [N_REQ];
    logic        [DATA_W-1:0] id_arr_s [N_REQ];

    logic                     found_s;
    logic [IDX_W-1:0]         win_s;
    logic signed [DATA_W-1:0] sel_x_s;
    logic signed [DATA_W-1:0] sel_y_s;
    logic                     in_bounds_s;
    logic [ADDR_W-1:0]        lin_addr_s;
    logic                     match_s;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = {N_REQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign x_arr_s[g]  = bus.req_x[g*DATA_W +: DATA_W];
        assign y_arr_s[g]  = bus.req_y[g*DATA_W +: DATA_W];
        assign id_arr_s[g] = bus.req_id[g*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.req),
        .adv     (state_q == RESP),
        .adv_idx (win_q),
        .found   (found_s),
        .win_idx (win_s)
    );

    assign sel_x_s     = x_arr_s[win_s];
    assign sel_y_s     = y_arr_s[win_s];
    assign in_bounds_s = (sel_x_s >= ZERO_S) && (sel_x_s <= GMAX_S) &&
                         (sel_y_s >= ZERO_S) && (sel_y_s <= GMAX_S);
    assign lin_addr_s  = ADDR_W'(sel_x_s * GN_S + sel_y_s);
    assign match_s     = (op_q == OP_CLAIM) ? (bus.mem_dout == EMPTY_V) : (bus.mem_dout == id_q);

    // Next-state and registered-output decode; strobes follow the state being entered
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        op_d    = op_q;
        id_d    = id_q;
        addr_d  = addr_q;
        din_d   = din_q;
        gnt_d   = {N_REQ{1'b0}};
        ok_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    win_d = win_s;
                    op_d  = bus.req_op[win_s];
                    id_d  = id_arr_s[win_s];
                    if (in_bounds_s) begin
                        addr_d  = lin_addr_s;
                        state_d = RD;
                    end else begin
                        gnt_d   = onehot(win_s);
                        state_d = RESP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                state_d = CHK;
            end
            CHK: begin
                if (match_s) begin
                    din_d   = (op_q == OP_CLAIM) ? id_q : EMPTY_V;
                    state_d = WR;
                end else begin
                    gnt_d   = onehot(win_q);
                    state_d = RESP;
                end
            end
            WR: begin
                gnt_d   = onehot(win_q);
                ok_d    = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rd_d   = (state_d == RD);
        wr_d   = (state_d == WR);
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            win_q   <= {IDX_W{1'b0}};
            op_q    <= OP_CLAIM;
            id_q    <= {DATA_W{1'b0}};
            addr_q  <= {ADDR_W{1'b0}};
            din_q   <= {DATA_W{1'b0}};
            gnt_q   <= {N_REQ{1'b0}};
            ok_q    <= 1'b0;
            busy_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            op_q    <= op_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            gnt_q   <= gnt_d;
            ok_q    <= ok_d;
            busy_q  <= busy_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.ok        = ok_q;
    assign bus.busy      = busy_q;
    assign bus.mem_read  = rd_q;
    assign bus.mem_write = wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_din   = din_q;

endmodule
